// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared state encoding and constants for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;

    // Opcode that parks the fetcher when halt detection is compiled in.
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DATA   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Single-entry instruction fetch controller: strobes memory, buffers one word, hands it to the decoder.
// Optional feature: define FETCH_HALT_DETECT_EN to park in HALTED after the halt opcode is consumed.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] addressBus,
    output logic              readFromInst,
    input  logic [DATA_W-1:0] instructionData,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              capture;
    logic              handshake;
    logic              halt_on_consume;

    assign handshake = (state == ST_HOLD) && instr_ready;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_on_consume = handshake && (instr_out == DATA_W'(HALT_OPCODE));
`else
    assign halt_on_consume = 1'b0;
`endif

    // A consumed halt opcode wins over a same-cycle redirect; otherwise a redirect
    // always restarts fetching at the target, and stop overrides everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        pc_next    = RESET_PC;
                    end
                end
                ST_FETCH: begin
                    if (branch_valid) begin
                        state_next = ST_FETCH;
                        pc_next    = branch_target;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (branch_valid) begin
                        state_next = ST_FETCH;
                        pc_next    = branch_target;
                    end else begin
                        state_next = ST_HOLD;
                        capture    = 1'b1;
                        pc_next    = pc + PC_INC;
                    end
                end
                ST_HOLD: begin
                    if (halt_on_consume) begin
                        state_next = ST_HALTED;
                    end else if (branch_valid) begin
                        state_next = ST_FETCH;
                        pc_next    = branch_target;
                    end else if (handshake) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    state_next = ST_HALTED;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr_out <= '0;
            instr_pc  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                instr_out <= instructionData;
                instr_pc  <= pc;
            end
        end
    end

    // Address is gated so the bus reads zero whenever no strobe is issued.
    assign addressBus   = (state == ST_FETCH) ? pc : '0;
    assign readFromInst = (state == ST_FETCH);
    assign instr_valid  = (state == ST_HOLD);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl; honours FETCH_HALT_DETECT_EN when defined.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic [15:0] addressBus;
    logic        readFromInst;
    logic [31:0] instructionData;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    int tests_run = 0;
    int failures  = 0;

    inst_fetch_ctrl #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .RESET_PC (16'h0000),
        .PC_STEP  (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .addressBus      (addressBus),
        .readFromInst    (readFromInst),
        .instructionData (instructionData),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 32'h1111_0000;
        if (a == 16'h0040) return 32'hFFFF_FFFF;
        return {a ^ 16'hA5A5, a};
    endfunction

    // Memory answers one cycle after a strobe; junk otherwise.
    always @(posedge clk) begin
        if (readFromInst) instructionData <= mem_word(addressBus);
        else              instructionData <= $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; branch_valid = 1'b0;
        branch_target = 16'h0000; instr_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({addressBus, readFromInst, instr_valid, busy} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got addr=%h rd=%b v=%b busy=%b, want all 0", addressBus, readFromInst, instr_valid, busy);
        end
        tests_run++;
        if ({instr_out, instr_pc} !== 48'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got out=%h pc=%h, want 0", instr_out, instr_pc);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_first_fetch();
        start = 1'b1; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus, busy, instr_valid} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL first_strobe: got rd=%b addr=%h busy=%b v=%b want 1 0000 1 0", readFromInst, addressBus, busy, instr_valid);
        end
        tick();
        tests_run++;
        if ({instr_valid, readFromInst} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL first_data_phase: got v=%b rd=%b want 0 0", instr_valid, readFromInst);
        end
        tick();
        tests_run++;
        if ({instr_valid, instr_out, instr_pc} !== {1'b1, 32'h1111_0000, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL first_present: got v=%b out=%h pc=%h want 1 11110000 0000", instr_valid, instr_out, instr_pc);
        end
        tick();
        instr_ready = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0001}) begin
            failures++;
            $display("[TB] FAIL first_next_addr: got rd=%b addr=%h want 1 0001", readFromInst, addressBus);
        end
    endtask

    task automatic test_backpressure();
        tick();
        tick();
        tests_run++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 16'h0001, mem_word(16'h0001)}) begin
            failures++;
            $display("[TB] FAIL stall_present: got v=%b pc=%h out=%h want 1 0001 %h", instr_valid, instr_pc, instr_out, mem_word(16'h0001));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({instr_valid, readFromInst, instr_pc, instr_out} !== {2'b10, 16'h0001, mem_word(16'h0001)}) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got v=%b rd=%b pc=%h out=%h", i, instr_valid, readFromInst, instr_pc, instr_out);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0002}) begin
            failures++;
            $display("[TB] FAIL stall_release: got rd=%b addr=%h want 1 0002", readFromInst, addressBus);
        end
    endtask

    task automatic test_branch();
        tick();
        branch_valid = 1'b1; branch_target = 16'h0500;
        tick();
        branch_valid = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus, instr_valid} !== {1'b1, 16'h0500, 1'b0}) begin
            failures++;
            $display("[TB] FAIL branch_data_redirect: got rd=%b addr=%h v=%b want 1 0500 0", readFromInst, addressBus, instr_valid);
        end
        tick();
        tick();
        tests_run++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 16'h0500, mem_word(16'h0500)}) begin
            failures++;
            $display("[TB] FAIL branch_target_word: got v=%b pc=%h out=%h want pc 0500", instr_valid, instr_pc, instr_out);
        end
        branch_valid = 1'b1; branch_target = 16'h0A00;
        tick();
        branch_valid = 1'b0;
        tests_run++;
        if ({instr_valid, readFromInst, addressBus} !== {2'b01, 16'h0A00}) begin
            failures++;
            $display("[TB] FAIL branch_hold_drop: got v=%b rd=%b addr=%h want 0 1 0a00", instr_valid, readFromInst, addressBus);
        end
        tick();
        tick();
        tests_run++;
        if ({instr_valid, instr_pc} !== {1'b1, 16'h0A00}) begin
            failures++;
            $display("[TB] FAIL branch_hold_word: got v=%b pc=%h want 1 0a00", instr_valid, instr_pc);
        end
        branch_valid = 1'b1; branch_target = 16'h0B00; instr_ready = 1'b1;
        tick();
        branch_valid = 1'b0; instr_ready = 1'b0;
        tests_run++;
        if ({instr_valid, readFromInst, addressBus} !== {2'b01, 16'h0B00}) begin
            failures++;
            $display("[TB] FAIL branch_with_handshake: got v=%b rd=%b addr=%h want 0 1 0b00", instr_valid, readFromInst, addressBus);
        end
        branch_valid = 1'b1; branch_target = 16'h0C00;
        tick();
        branch_valid = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0C00}) begin
            failures++;
            $display("[TB] FAIL branch_in_fetch: got rd=%b addr=%h want 1 0c00", readFromInst, addressBus);
        end
        tick();
        tick();
        tests_run++;
        if ({instr_pc, instr_out} !== {16'h0C00, mem_word(16'h0C00)}) begin
            failures++;
            $display("[TB] FAIL branch_fetch_word: got pc=%h out=%h want 0c00 %h", instr_pc, instr_out, mem_word(16'h0C00));
        end
    endtask

    task automatic test_wrap();
        branch_valid = 1'b1; branch_target = 16'hFFFF;
        tick();
        branch_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 16'hFFFF, 32'h5A5A_FFFF}) begin
            failures++;
            $display("[TB] FAIL wrap_top_word: got v=%b pc=%h out=%h want 1 ffff 5a5affff", instr_valid, instr_pc, instr_out);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL wrap_next_addr: got rd=%b addr=%h want 1 0000", readFromInst, addressBus);
        end
    endtask

    task automatic test_stop_priority();
        stop = 1'b1; start = 1'b1; branch_valid = 1'b1; branch_target = 16'h0300;
        tick();
        stop = 1'b0; start = 1'b0; branch_valid = 1'b0;
        tests_run++;
        if ({busy, readFromInst, instr_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL stop_priority: got busy=%b rd=%b v=%b want 0 0 0", busy, readFromInst, instr_valid);
        end
        branch_valid = 1'b1; branch_target = 16'h0300;
        tick();
        branch_valid = 1'b0;
        tests_run++;
        if ({busy, readFromInst} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_branch_ignored: got busy=%b rd=%b want 0 0", busy, readFromInst);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL restart_addr: got rd=%b addr=%h want 1 0000", readFromInst, addressBus);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({instr_valid, instr_pc} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored: got v=%b pc=%h want 1 0000", instr_valid, instr_pc);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if ({busy, instr_valid, readFromInst} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL stop_in_hold: got busy=%b v=%b rd=%b want 0 0 0", busy, instr_valid, readFromInst);
        end
    endtask

    task automatic test_halt_opcode();
        start = 1'b1;
        tick();
        start = 1'b0; branch_valid = 1'b1; branch_target = 16'h0040;
        tick();
        branch_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({instr_valid, instr_out} !== {1'b1, 32'hFFFF_FFFF}) begin
            failures++;
            $display("[TB] FAIL halt_word_present: got v=%b out=%h want 1 ffffffff", instr_valid, instr_out);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
        branch_valid = 1'b1; branch_target = 16'h0100; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({busy, readFromInst, instr_valid} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL halted_%0d: got busy=%b rd=%b v=%b want 1 0 0", i, busy, readFromInst, instr_valid);
            end
            tick();
        end
        branch_valid = 1'b0; start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halted_stop: got busy=%b want 0", busy);
        end
`else
        tests_run++;
        if ({busy, readFromInst, addressBus} !== {2'b11, 16'h0041}) begin
            failures++;
            $display("[TB] FAIL halt_opcode_ordinary: got busy=%b rd=%b addr=%h want 1 1 0041", busy, readFromInst, addressBus);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ordinary_stop: got busy=%b want 0", busy);
        end
`endif
    endtask

    task automatic test_reset_mid_hold();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tests_run++;
        if (instr_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_reach_hold: got v=%b want 1", instr_valid);
        end
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({addressBus, readFromInst, instr_out, instr_pc, instr_valid, busy} !== 67'd0) begin
            failures++;
            $display("[TB] FAIL midreset_async: got addr=%h rd=%b out=%h pc=%h v=%b busy=%b want all 0", addressBus, readFromInst, instr_out, instr_pc, instr_valid, busy);
        end
        tick();
        reset = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if ({instr_valid, readFromInst, busy} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL midreset_quiet%0d: got v=%b rd=%b busy=%b want 0 0 0", i, instr_valid, readFromInst, busy);
            end
        end
        instr_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({readFromInst, addressBus} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got rd=%b addr=%h want 1 0000", readFromInst, addressBus);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Program-order model: the next expected address advances on every accepted
    // instruction and jumps to the target on any redirect while busy.
    task automatic test_random_stream();
        logic [15:0] exp_pc;
        logic [15:0] prev_pc;
        logic [31:0] prev_out;
        logic        prev_stall;
        logic        prev_drop;
        int          delivered;
        exp_pc = 16'h0000; prev_pc = '0; prev_out = '0;
        prev_stall = 1'b0; prev_drop = 1'b0; delivered = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            instr_ready  = ($urandom_range(9, 0) < 7);
            branch_valid = ($urandom_range(9, 0) == 0);
            branch_target = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom_range(16'hFFFF, 16'h0100));
            if (prev_stall) begin
                tests_run++;
                if ({instr_valid, instr_pc, instr_out} !== {1'b1, prev_pc, prev_out}) begin
                    failures++;
                    $display("[TB] FAIL rand_stable@%0d: got v=%b pc=%h out=%h want 1 %h %h", cyc, instr_valid, instr_pc, instr_out, prev_pc, prev_out);
                end
            end
            if (prev_drop) begin
                tests_run++;
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand_drop@%0d: got v=%b want 0", cyc, instr_valid);
                end
            end
            if (readFromInst) begin
                tests_run++;
                if (addressBus !== exp_pc) begin
                    failures++;
                    $display("[TB] FAIL rand_addr@%0d: got %h want %h", cyc, addressBus, exp_pc);
                end
            end
            if (instr_valid && instr_ready) begin
                tests_run++;
                if ({instr_pc, instr_out} !== {exp_pc, mem_word(exp_pc)}) begin
                    failures++;
                    $display("[TB] FAIL rand_deliver@%0d: got pc=%h out=%h want %h %h", cyc, instr_pc, instr_out, exp_pc, mem_word(exp_pc));
                end
                delivered++;
                exp_pc = exp_pc + 16'd1;
            end
            if (branch_valid && busy) exp_pc = branch_target;
            prev_stall = instr_valid && !instr_ready && !branch_valid;
            prev_drop  = instr_valid && !instr_ready && branch_valid;
            prev_pc    = instr_pc;
            prev_out   = instr_out;
            tick();
        end
        branch_valid = 1'b0; instr_ready = 1'b0;
        tests_run++;
        if (delivered < 50) begin
            failures++;
            $display("[TB] FAIL rand_throughput: got %0d deliveries want >= 50", delivered);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_branch();
        test_wrap();
        test_stop_priority();
        test_halt_opcode();
        test_reset_mid_hold();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
